// File: rtl/esp_cmd_decoder_if.sv
// Command-word bus from the ESP SPI slave command FIFO into the decoder.
//   i_cmd     : 32-bit command word ([31:24] opcode, [23:16] address/argument, [15:0] data)
//   i_cmd_vld : i_cmd is valid this cycle; consumed unconditionally (no back-pressure)
// master modport drives the bus (FIFO side / bench), slave modport receives it (decoder).
interface esp_cmd_decoder_if;
  logic [31:0] i_cmd;
  logic        i_cmd_vld;

  modport master (output i_cmd, output i_cmd_vld);
  modport slave  (input  i_cmd, input  i_cmd_vld);
endinterface

// File: rtl/esp_cmd_decoder.sv
// Command decoder and acquisition sequencer (adc_clk domain).
// Decodes command words into a bank of 16-bit control registers and runs a
// timed burst of one-cycle acquisition start pulses.
// Ports:
//   adc_clk    : clock, rising edge
//   rst_n      : synchronous active-low reset
//   i_cmd_if   : command bus (slave modport)
//   o_regs     : flattened register bank, reg k at [16k+15:16k]
//   o_start    : one-cycle acquisition start pulse
//   o_busy     : sequencer running
//   o_shot_cnt : pulses issued in the current or most recent sequence
//   o_err_cnt  : rejected-command counter, saturating at 255
module esp_cmd_decoder #(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                     adc_clk,
  input  logic                     rst_n,
  esp_cmd_decoder_if.slave         i_cmd_if,
  output logic [NUM_REGS*16-1:0]   o_regs,
  output logic                     o_start,
  output logic                     o_busy,
  output logic [15:0]              o_shot_cnt,
  output logic [7:0]               o_err_cnt
);

  localparam int unsigned AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NREG_W   = 8'(NUM_REGS);
  localparam logic [7:0]  OP_WR    = 8'h81;
  localparam logic [7:0]  OP_START = 8'h82;
  localparam logic [7:0]  OP_STOP  = 8'h83;
  localparam logic [7:0]  OP_NOP   = 8'h8F;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state;
  logic [15:0] r_regs [NUM_REGS];
  logic        r_start;
  logic [15:0] r_shot_cnt;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_period;
  logic [15:0] r_tmr;
  logic [15:0] r_left;
  logic        r_cont;

  state_t      w_state_nxt;
  logic        w_start_nxt;
  logic [15:0] w_shot_nxt;
  logic [7:0]  w_err_nxt;
  logic [15:0] w_period_nxt;
  logic [15:0] w_tmr_nxt;
  logic [15:0] w_left_nxt;
  logic        w_cont_nxt;
  logic        w_reg_we;
  logic        w_reject;

  logic [7:0]  w_op;
  logic [7:0]  w_addr;
  logic [15:0] w_data;
  logic        w_vld;
  logic [15:0] w_period0;

  assign w_op   = i_cmd_if.i_cmd[31:24];
  assign w_addr = i_cmd_if.i_cmd[23:16];
  assign w_data = i_cmd_if.i_cmd[15:0];
  assign w_vld  = i_cmd_if.i_cmd_vld;

  // A zero period in reg0 runs at one pulse per cycle.
  assign w_period0 = (r_regs[0] == 16'd0) ? 16'd1 : r_regs[0];

  // State and sequencer registers.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_start    <= 1'b0;
      r_shot_cnt <= 16'd0;
      r_err_cnt  <= 8'd0;
      r_period   <= 16'd1;
      r_tmr      <= 16'd0;
      r_left     <= 16'd0;
      r_cont     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start    <= w_start_nxt;
      r_shot_cnt <= w_shot_nxt;
      r_err_cnt  <= w_err_nxt;
      r_period   <= w_period_nxt;
      r_tmr      <= w_tmr_nxt;
      r_left     <= w_left_nxt;
      r_cont     <= w_cont_nxt;
    end
  end

  // Next-state: sequencer advance first, then command decode may override.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_nxt  = 1'b0;
    w_shot_nxt   = r_start ? (r_shot_cnt + 16'd1) : r_shot_cnt;
    w_err_nxt    = r_err_cnt;
    w_period_nxt = r_period;
    w_tmr_nxt    = r_tmr;
    w_left_nxt   = r_left;
    w_cont_nxt   = r_cont;
    w_reg_we     = 1'b0;
    w_reject     = 1'b0;

    // r_left counts pulses still owed after the one currently on o_start.
    if (r_state == ST_RUN) begin
      if (r_start && !r_cont && (r_left == 16'd0)) begin
        w_state_nxt = ST_IDLE;
      end else if (r_tmr == 16'd0) begin
        w_start_nxt = 1'b1;
        w_tmr_nxt   = r_period - 16'd1;
        if (!r_cont) begin
          w_left_nxt = r_left - 16'd1;
        end
      end else begin
        w_tmr_nxt = r_tmr - 16'd1;
      end
    end

    if (w_vld) begin
      case (w_op)
        OP_WR: begin
          if (w_addr < NREG_W) begin
            w_reg_we = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
        OP_START: begin
          if (r_state == ST_IDLE) begin
            w_state_nxt  = ST_RUN;
            w_start_nxt  = 1'b1;
            w_shot_nxt   = 16'd0;
            w_period_nxt = w_period0;
            w_tmr_nxt    = w_period0 - 16'd1;
            w_left_nxt   = w_data - 16'd1;
            w_cont_nxt   = (w_data == 16'd0);
          end else begin
            w_reject = 1'b1;
          end
        end
        OP_STOP: begin
          if (r_state == ST_RUN) begin
            w_state_nxt = ST_IDLE;
            w_start_nxt = 1'b0;
          end
        end
        OP_NOP: begin
        end
        default: begin
          w_reject = 1'b1;
        end
      endcase
    end

    if (w_reject && (r_err_cnt != 8'hFF)) begin
      w_err_nxt = r_err_cnt + 8'd1;
    end
  end

  // Control register bank; address range already checked by the decoder.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        r_regs[k] <= 16'd0;
      end
    end else if (w_reg_we) begin
      r_regs[w_addr[AW-1:0]] <= w_data;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
    assign o_regs[16*g +: 16] = r_regs[g];
  end

  assign o_start    = r_start;
  assign o_busy     = (r_state == ST_RUN);
  assign o_shot_cnt = r_shot_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_esp_cmd_decoder.sv
// Self-checking bench for esp_cmd_decoder: directed test-plan scenarios plus
// randomized command traffic, compared every cycle against a pulse-schedule model.
module tb_esp_cmd_decoder;

  localparam int NR = 8;

  logic             adc_clk = 1'b0;
  logic             rst_n;
  logic [NR*16-1:0] o_regs;
  logic             o_start;
  logic             o_busy;
  logic [15:0]      o_shot_cnt;
  logic [7:0]       o_err_cnt;

  esp_cmd_decoder_if u_if ();

  esp_cmd_decoder #(.NUM_REGS(NR)) u_dut (
    .adc_clk    (adc_clk),
    .rst_n      (rst_n),
    .i_cmd_if   (u_if),
    .o_regs     (o_regs),
    .o_start    (o_start),
    .o_busy     (o_busy),
    .o_shot_cnt (o_shot_cnt),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a sequence is described by its start cycle, period and count;
  // pulses fall at s+1+k*P, so each cycle's expected outputs follow from arithmetic.
  int          cyc = 0;
  logic [15:0] m_regs [NR];
  int          m_err;
  int          m_shot;
  bit          m_busy;
  int          m_s;
  int          m_p;
  int          m_c;
  bit          m_valid = 1'b0;
  int          pulse_log[$];

  function automatic bit m_pulse(input int t);
    return m_busy && (((t - m_s - 1) % m_p) == 0);
  endfunction

  task automatic m_err_inc();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_update(input bit rst, input logic [31:0] cmd, input bit vld);
    bit nb;
    int nshot;
    bit pulse;
    if (!rst) begin
      for (int k = 0; k < NR; k++) m_regs[k] = 16'd0;
      m_err = 0; m_shot = 0; m_busy = 1'b0; m_s = 0; m_p = 1; m_c = 0;
      m_valid = 1'b1;
      return;
    end
    pulse = m_pulse(cyc);
    nb    = m_busy;
    nshot = (m_shot + (pulse ? 1 : 0)) % 65536;
    if (pulse && m_c != 0 && ((cyc - m_s - 1) / m_p) == m_c - 1) nb = 1'b0;
    if (vld) begin
      case (cmd[31:24])
        8'h81: begin
          if (int'(cmd[23:16]) < NR) m_regs[int'(cmd[23:16])] = cmd[15:0];
          else m_err_inc();
        end
        8'h82: begin
          if (m_busy) m_err_inc();
          else begin
            nb    = 1'b1;
            m_s   = cyc;
            m_p   = (m_regs[0] == 16'd0) ? 1 : int'(m_regs[0]);
            m_c   = int'(cmd[15:0]);
            nshot = 0;
          end
        end
        8'h83: nb = 1'b0;
        8'h8F: ;
        default: m_err_inc();
      endcase
    end
    m_busy = nb;
    m_shot = nshot;
  endtask

  // One clock cycle: drive, sample at negedge, compare, advance model.
  task automatic step(input bit rst, input logic [31:0] cmd, input bit vld);
    logic [255:0] ev;
    rst_n         = rst;
    u_if.i_cmd    = cmd;
    u_if.i_cmd_vld = vld;
    @(negedge adc_clk);
    if (o_start === 1'b1) pulse_log.push_back(cyc);
    if (m_valid) begin
      ev = '0;
      for (int k = 0; k < NR; k++) ev[16*k +: 16] = m_regs[k];
      check("start", 256'(o_start),    256'(m_pulse(cyc)));
      check("busy",  256'(o_busy),     256'(m_busy));
      check("shot",  256'(o_shot_cnt), 256'(m_shot));
      check("err",   256'(o_err_cnt),  256'(m_err));
      check("regs",  256'(o_regs),     ev);
    end
    model_update(rst, cmd, vld);
    @(posedge adc_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 32'h0, 1'b0);
  endtask

  task automatic check_log(input string tag, input int idx, input int exp);
    int v;
    v = (idx < pulse_log.size()) ? pulse_log[idx] : -1;
    check(tag, 256'(v), 256'(exp));
  endtask

  int n;

  initial begin
    rst_n          = 1'b0;
    u_if.i_cmd     = 32'h0;
    u_if.i_cmd_vld = 1'b0;
    @(posedge adc_clk);
    #1;

    // Reset and register writes
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h8100_0055, 1'b1);
    step(1'b1, 32'h8100_1234, 1'b1);
    step(1'b1, 32'h8107_ABCD, 1'b1);
    idle(1);
    check("reg0_direct", 256'(o_regs[15:0]), 256'(16'h1234));
    check("reg7_direct", 256'(o_regs[127:112]), 256'(16'hABCD));

    // Rejected commands and saturation
    step(1'b1, 32'h8108_0001, 1'b1);
    step(1'b1, 32'h7F00_0000, 1'b1);
    step(1'b1, 32'h8F00_0010, 1'b1);
    idle(1);
    check("err_two", 256'(o_err_cnt), 256'(2));
    for (int i = 0; i < 300; i++) step(1'b1, 32'h0000_0000, 1'b1);
    idle(1);
    check("err_sat", 256'(o_err_cnt), 256'(255));

    // Finite burst, period 4, count 3
    step(1'b1, 32'h8100_0004, 1'b1);
    pulse_log.delete();
    n = cyc;
    step(1'b1, 32'h8200_0003, 1'b1);
    idle(12);
    check("burst_n", 256'(pulse_log.size()), 256'(3));
    check_log("burst_p0", 0, n + 1);
    check_log("burst_p1", 1, n + 5);
    check_log("burst_p2", 2, n + 9);
    check("burst_shot", 256'(o_shot_cnt), 256'(3));

    // Continuous run, period 1, then stop
    step(1'b1, 32'h8100_0000, 1'b1);
    step(1'b1, 32'h8200_0000, 1'b1);
    idle(6);
    step(1'b1, 32'h8300_0000, 1'b1);
    idle(3);

    // Start/stop back to back
    step(1'b1, 32'h8200_0000, 1'b1);
    step(1'b1, 32'h8300_0000, 1'b1);
    idle(2);

    // Start while busy, period change applies only to next start
    step(1'b1, 32'h8100_000A, 1'b1);
    pulse_log.delete();
    n = cyc;
    step(1'b1, 32'h8200_0005, 1'b1);
    idle(9);
    step(1'b1, 32'h8100_0002, 1'b1);
    step(1'b1, 32'h8200_0001, 1'b1);
    idle(45);
    check("busy_n", 256'(pulse_log.size()), 256'(5));
    for (int i = 0; i < 5; i++) check_log("busy_spacing", i, n + 1 + 10 * i);
    step(1'b1, 32'h8200_0003, 1'b1);
    idle(8);

    // Reset mid-sequence
    step(1'b1, 32'h8200_0000, 1'b1);
    idle(5);
    step(1'b0, 32'h8100_1111, 1'b1);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] c;
      int          r;
      bit          v;
      bit          rb;
      r  = int'($urandom % 10);
      v  = ($urandom % 3) != 0;
      rb = ($urandom % 150) != 0;
      case (r)
        0, 1, 2, 3: begin
          c = {8'h81, 8'($urandom % 10), 16'($urandom)};
          if (c[23:16] == 8'd0) c[15:0] = 16'($urandom % 4);
        end
        4, 5: c = {8'h82, 8'($urandom), 16'($urandom % 5)};
        6:    c = {8'h83, 24'($urandom)};
        7:    c = {8'h8F, 24'($urandom)};
        default: c = $urandom;
      endcase
      step(rb, c, v);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
